muxn_rr: RTL

Parametrised N-channel, WIDTH-bit multiplexer with a registered output stage and valid/ready handshaking. It generalises the fixed 4-bit 2:1 datapath mux to any channel count and width. It adds a round-robin arbitration mode alongside direct select. It sits between multiple producers (register-file read ports, ALU result sources) and a single consumer that may stall.

---
 rtl/mux_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/muxn_rr.sv | 102 ++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the N-channel round-robin mux.
// Mode encodings, size limits and a flattened-bus channel extractor.
package mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  localparam int MAX_N = 16;
  localparam int MAX_W = 32;
  localparam int BUSW  = MAX_N * MAX_W;

  // Channel i of a flattened bus with w bits per channel.
  // The caller truncates the result to its own width.
  function automatic logic [MAX_W-1:0] get_ch(
    input logic [BUSW-1:0] bus,
    input int              i,
    input int              w
  );
    logic [BUSW-1:0] sh;
    sh = bus >> (i * w);
    return sh[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: search starts at ptr and wraps modulo N.
// ptr moves past the winner only when the caller commits the grant.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [SELW-1:0] grant_idx,
  output logic            grant_vld
);

  logic [SELW-1:0] ptr_q, ptr_d;

  // First requester at or after ptr, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!grant_vld && req[SELW'(idx)]) begin
        grant_vld = 1'b1;
        grant_idx = SELW'(idx);
      end
    end
  end

  // Next pointer: one past a committed winner, else hold.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && grant_vld) begin
      if (grant_idx == SELW'(N - 1)) ptr_d = '0;
      else                          ptr_d = grant_idx + SELW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/muxn_rr.sv
// N-channel mux with one-deep registered output and valid/ready.
// Direct select or round-robin; in_ready is combinational on out_ready.
module muxn_rr
  import mux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [SELW-1:0]    s,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic             vld_q, vld_d;

  logic             can_load;
  logic             sel_vld;
  logic [SELW-1:0]  arb_idx;
  logic             arb_vld;
  logic [SELW-1:0]  gnt_idx;
  logic             gnt_vld;
  logic             load;
  logic [BUSW-1:0]  bus_ext;

  assign can_load = !vld_q || out_ready;
  assign bus_ext  = BUSW'(in_data);

  // Direct select: out-of-range s simply grants nothing.
  always_comb begin
    sel_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (s == SELW'(i) && in_valid[i]) sel_vld = 1'b1;
    end
  end

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (in_valid),
    .advance   (reset && can_load && mode == MODE_RR),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  assign gnt_idx = (mode == MODE_RR) ? arb_idx : s;
  assign gnt_vld = (mode == MODE_RR) ? arb_vld : sel_vld;
  assign load    = reset && can_load && gnt_vld;

  // One-hot accept for the granted channel; quiet during reset.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (load && gnt_idx == SELW'(i)) in_ready[i] = 1'b1;
    end
  end

  // Load replaces (even on a same-cycle drain); drain alone clears valid.
  always_comb begin
    data_d = data_q;
    sel_d  = sel_q;
    vld_d  = vld_q;
    if (load) begin
      data_d = WIDTH'(get_ch(bus_ext, int'(gnt_idx), WIDTH));
      sel_d  = gnt_idx;
      vld_d  = 1'b1;
    end else if (vld_q && out_ready) begin
      vld_d  = 1'b0;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      sel_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      sel_q  <= sel_d;
      vld_q  <= vld_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = vld_q;

endmodule
